// File: rtl/instr_word_packer.sv
// Packs decoded instruction fields into 32-bit words, buffers them in a small FIFO and
// streams them into instruction memory from a base address. Optional build macro: FIELD_CHECK_EN.
module instr_word_packer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [15:0]       word_count,
    output logic              busy,
    output logic              err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        CLS_RTYPE = 3'd0,
        CLS_DIVI  = 3'd1,
        CLS_ADDI  = 3'd2,
        CLS_LW    = 3'd3,
        CLS_ORI   = 3'd4,
        CLS_SW    = 3'd5,
        CLS_MULI  = 3'd6,
        CLS_BEQ   = 3'd7
    } instr_class_e;

    logic [31:0]       fifo_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       words_q, words_d;

    logic              full, empty;
    logic              accept, push, pop, drop;
    logic [31:0]       packed_word;
    logic [5:0]        opcode;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Ready/strobe are gated by rst_n so nothing moves while reset is held.
    assign in_ready = rst_n & ~full & ~start;
    assign accept   = in_valid & in_ready;
    assign pop      = rst_n & ~empty & mem_ready;
    assign push     = accept & ~drop;

    assign mem_we     = pop;
    assign mem_addr   = addr_q;
    assign mem_wdata  = fifo_q[rd_ptr_q];
    assign word_count = words_q;
    assign busy       = ~empty | accept;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        opcode      = {3'b000, in_class};
        packed_word = {opcode, in_rs, in_rt, in_imm};
        if (instr_class_e'(in_class) == CLS_RTYPE) begin
            packed_word = {6'b0, in_rs, in_rt, in_rd, 5'b0, in_funct};
        end
    end

`ifdef FIELD_CHECK_EN
    logic err_q;
    logic bad_funct, bad_dest;

    always_comb begin
        bad_funct = 1'b0;
        bad_dest  = 1'b0;
        if (instr_class_e'(in_class) == CLS_RTYPE) begin
            bad_funct = !(in_funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
            bad_dest  = (in_rd == 5'd0);
        end else if (instr_class_e'(in_class) != CLS_BEQ &&
                     instr_class_e'(in_class) != CLS_SW) begin
            bad_dest  = (in_rt == 5'd0);
        end
        drop = bad_funct | bad_dest;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept && drop) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign drop = 1'b0;
    assign err  = 1'b0;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        words_d  = words_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (pop) begin
            addr_d = addr_q + ADDR_W'(4);
            if (words_q != 16'hFFFF) words_d = words_q + 16'd1;
        end

        // A start overrides any same-edge write advance; the write itself used the old address.
        if (start) begin
            addr_d  = base_addr & ~ADDR_W'(3);
            words_d = 16'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            words_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            words_q  <= words_d;
        end
    end

    // NOTE: the storage array is reset too, because the head word must read 0 out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else if (push) begin
            fifo_q[wr_ptr_q] <= packed_word;
        end
    end

endmodule

// File: tb/tb_instr_word_packer.sv
// Directed self-checking bench for instr_word_packer; expectations follow FIELD_CHECK_EN when defined.
module tb_instr_word_packer;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_class;
    logic [4:0]        in_rs, in_rt, in_rd;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [15:0]       word_count;
    logic              busy;
    logic              err;

    int n_vec = 0;
    int n_err = 0;

    instr_word_packer #(.DEPTH(4), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_class   (in_class),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_funct   (in_funct),
        .in_imm     (in_imm),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .word_count (word_count),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm);
        in_valid = 1'b1;
        in_class = cls;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_funct = funct;
        in_imm   = imm;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] base);
        start     = 1'b1;
        base_addr = base;
        #1;
        check("ready_in_start", 32'(in_ready), 32'd0);
        tick();
        start = 1'b0;
    endtask

    logic [31:0] fill_exp [5];

    initial begin
        fill_exp[0] = 32'h08010001;
        fill_exp[1] = 32'h08020002;
        fill_exp[2] = 32'h08030003;
        fill_exp[3] = 32'h08040004;
        fill_exp[4] = 32'h08050005;

        rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        in_class = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_funct = '0; in_imm = '0;
        mem_ready = 1'b1;

        // Reset state
        tick(); tick();
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_we",    32'(mem_we),   32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_wdata", mem_wdata,     32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        check("rst_err",   32'(err),      32'd0);
        rst_n = 1'b1;
        tick();

        // Single addi, base bits [1:0] masked off
        do_start(10'h043);
        drive(3'd2, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0005);
        #1;
        check("addi_ready", 32'(in_ready), 32'd1);
        check("addi_busy",  32'(busy),     32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check("addi_we",    32'(mem_we),   32'd1);
        check("addi_addr",  32'(mem_addr), 32'h040);
        check("addi_data",  mem_wdata,     32'h08220005);
        check("addi_cnt0",  32'(word_count), 32'd0);
        tick();
        check("addi_cnt1",  32'(word_count), 32'd1);
        check("addi_idle",  32'(mem_we),   32'd0);
        check("addi_nbusy", 32'(busy),     32'd0);
        check("addi_next",  32'(mem_addr), 32'h044);

        // R-type then lw back-to-back
        do_start(10'h040);
        check("start_cnt", 32'(word_count), 32'd0);
        drive(3'd0, 5'd3, 5'd4, 5'd5, 6'h20, 16'h0000);
        tick();
        drive(3'd3, 5'd0, 5'd6, 5'd0, 6'd0, 16'hFFFC);
        #1;
        check("rt_we",   32'(mem_we),   32'd1);
        check("rt_addr", 32'(mem_addr), 32'h040);
        check("rt_data", mem_wdata,     32'h00642820);
        tick();
        in_valid = 1'b0;
        #1;
        check("lw_we",   32'(mem_we),   32'd1);
        check("lw_addr", 32'(mem_addr), 32'h044);
        check("lw_data", mem_wdata,     32'h0C06FFFC);
        tick();
        check("b2b_cnt", 32'(word_count), 32'd2);

        // Fill to full with memory stalled, then drain
        do_start(10'h100);
        mem_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive(3'd2, 5'd0, 5'(k), 5'd0, 6'd0, 16'(k));
            #1;
            check("fill_ready", 32'(in_ready), 32'd1);
            tick();
        end
        drive(3'd2, 5'd0, 5'd5, 5'd0, 6'd0, 16'd5);
        #1;
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_busy",  32'(busy),     32'd1);
        check("stall_we",   32'(mem_we),   32'd0);
        mem_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            check("drain_we",   32'(mem_we),   32'd1);
            check("drain_addr", 32'(mem_addr), 32'h100 + 32'(4 * j));
            check("drain_data", mem_wdata,     fill_exp[j]);
            if (j == 0) check("drain_ready0", 32'(in_ready), 32'd0);
            if (j == 1) check("drain_ready1", 32'(in_ready), 32'd1);
            tick();
            if (j == 1) in_valid = 1'b0;
        end
        check("drain_empty", 32'(mem_we), 32'd0);
        check("drain_cnt",   32'(word_count), 32'd5);

        // Address wrap
        do_start(10'h3FC);
        drive(3'd5, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0010);
        tick();
        drive(3'd5, 5'd3, 5'd4, 5'd0, 6'd0, 16'h0020);
        #1;
        check("sw0_addr", 32'(mem_addr), 32'h3FC);
        check("sw0_data", mem_wdata,     32'h14220010);
        tick();
        in_valid = 1'b0;
        #1;
        check("sw1_we",   32'(mem_we),   32'd1);
        check("sw1_addr", 32'(mem_addr), 32'h000);
        check("sw1_data", mem_wdata,     32'h14640020);
        tick();
        check("wrap_next", 32'(mem_addr), 32'h004);

        // Reset with words buffered
        mem_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive(3'd2, 5'd0, 5'(k), 5'd0, 6'd0, 16'(k));
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("buf_busy", 32'(busy), 32'd1);
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("inrst_we",    32'(mem_we),   32'd0);
        check("inrst_ready", 32'(in_ready), 32'd0);
        tick();
        check("mrst_we",    32'(mem_we),      32'd0);
        check("mrst_busy",  32'(busy),        32'd0);
        check("mrst_cnt",   32'(word_count),  32'd0);
        check("mrst_wdata", mem_wdata,        32'd0);
        check("mrst_addr",  32'(mem_addr),    32'd0);
        rst_n = 1'b1;
        tick();
        check("post_we",   32'(mem_we), 32'd0);
        check("post_busy", 32'(busy),   32'd0);

        // Illegal funct, then a valid ori
        do_start(10'h200);
        drive(3'd0, 5'd0, 5'd0, 5'd0, 6'h3F, 16'h0000);
        tick();
        in_valid = 1'b0;
        #1;
`ifdef FIELD_CHECK_EN
        check("bad_we",  32'(mem_we), 32'd0);
        check("bad_err", 32'(err),    32'd1);
`else
        check("bad_we",   32'(mem_we), 32'd1);
        check("bad_data", mem_wdata,   32'h0000003F);
        check("bad_err",  32'(err),    32'd0);
`endif
        tick();
        drive(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 16'h00FF);
        tick();
        in_valid = 1'b0;
        #1;
        check("ori_we",   32'(mem_we), 32'd1);
        check("ori_data", mem_wdata,   32'h102200FF);
`ifdef FIELD_CHECK_EN
        check("ori_addr", 32'(mem_addr), 32'h200);
        check("ori_err",  32'(err),      32'd1);
`else
        check("ori_addr", 32'(mem_addr), 32'h204);
        check("ori_err",  32'(err),      32'd0);
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
